mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port, fixed-latency memory between the instruction-fetch stage and the data-access stage (the MemRead/MemWrite path decoded by the control unit).
- Grants one access at a time and sequences the memory command for MEM_LAT cycles.
- Returns read data with a one-cycle valid pulse.
- Drives a pipeline stall while any requester is unserved.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MEM_LAT, 2, memory read latency in cycles (>=1). Read data is valid at the end of the MEM_LAT-th command cycle.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- if_req  in  1  fetch request; held until if_valid.
- if_addr  in  ADDR_W  fetch address (PC).
- if_rdata  out  DATA_W  fetched instruction; holds its value until the next fetch completes.
- if_valid  out  1  one-cycle pulse when a fetch completes.
- d_read  in  1  data read request (MemRead); held until d_valid.
- d_write  in  1  data write request (MemWrite); held until d_valid.
- d_addr  in  ADDR_W  data address (ALU result).
- d_wdata  in  DATA_W  store data.
- d_rdata  out  DATA_W  load data; holds its value until the next data read completes.
- d_valid  out  1  one-cycle pulse when a data read or write completes.
- stall  out  1  pipeline freeze.
- mem_en  out  1  memory command active.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE, cnt=0.
  - if_valid=d_valid=0, if_rdata=d_rdata=0.
  - mem_en=mem_we=0, mem_addr=mem_wdata=0.
  - last_grant=FETCH, so data wins the first conflict.
  - Reset mid-access aborts the access: no valid pulse, memory command drops the next cycle.
- States: IDLE, DATA, FETCH.
- IDLE:
  - A request is eligible only if its own valid is 0 in this cycle. This covers requesters that are still holding the line in their completion cycle.
  - Only data eligible -> DATA.
  - Only fetch eligible -> FETCH.
  - Both eligible -> FETCH if last_grant=DATA, else DATA (alternating, no starvation).
  - On transition: latch addr, wdata and we into mem_* registers; we = d_write. Set cnt=0 and update last_grant.
- DATA/FETCH:
  - mem_en=1; mem_we/mem_addr/mem_wdata are held stable for the entire access. mem_we=0 in FETCH.
  - cnt increments each cycle.
  - When cnt==MEM_LAT-1: capture mem_rdata into d_rdata or if_rdata (d_rdata only for reads), pulse the matching valid next cycle, and return to IDLE.
  - Writes complete after the same MEM_LAT cycles; d_rdata is unchanged.
- Latency: request seen in IDLE at cycle t -> valid high at cycle t+MEM_LAT+1. mem_en is high for cycles t+1..t+MEM_LAT.
- d_read and d_write both high: treated as a write; d_rdata is unchanged.
- Requests changing while their access is in flight are ignored, because operands are latched at grant.
- stall = (if_req & ~if_valid) | ((d_read|d_write) & ~d_valid). It is combinational from registered state and inputs and is low in the cycle both pending requesters see their valid.
- The valid pulses are exactly one cycle. if_valid and d_valid are never high in the same cycle.

Test Plan:
- Reset: hold rst 2 cycles during a DATA access -> state IDLE, mem_en=0, no d_valid, all outputs 0.
- Fetch only, MEM_LAT=2: if_req=1, if_addr=0x40, mem_rdata=0x00500093 at the 2nd command cycle -> mem_en high 2 cycles, if_valid pulse at t+3, if_rdata=0x00500093, stall low in cycle t+3.
- Load: d_read=1, d_addr=0x100, mem_rdata=0xDEADBEEF -> mem_we=0, d_valid at t+3, d_rdata=0xDEADBEEF; if_rdata is unchanged.
- Store: d_write=1, d_addr=0x104, d_wdata=0x12345678 -> mem_we=1 and mem_addr/mem_wdata stable for 2 cycles, d_valid at t+3, d_rdata is unchanged.
- Conflict: if_req and d_read asserted together after reset -> DATA is served first (d_valid at t+3), then FETCH (if_valid at t+6). stall stays high from t to t+5 and is low at t+6.
- Back-to-back alternation: both requesters immediately re-request after each valid for 3 rounds -> grants alternate D,F,D,F,D,F with no repeated grant while the other is pending.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, data and memory-side signals shared by mem_port_arbiter.
//   slave  : arbiter view (takes requests and mem_rdata, drives responses and command)
//   master : requester/memory view (drives requests and mem_rdata)
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    // Instruction fetch
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_valid;
    // Data access
    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_valid;
    // Pipeline freeze
    logic              stall;
    // Memory command
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, d_read, d_write, d_addr, d_wdata, mem_rdata,
        output if_rdata, if_valid, d_rdata, d_valid, stall,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, d_read, d_write, d_addr, d_wdata, mem_rdata,
        input  if_rdata, if_valid, d_rdata, d_valid, stall,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port memory between instruction fetch and data access.
// One access at a time; the command is held for MEM_LAT cycles and the result is returned
// with a one-cycle valid pulse. Ties alternate so neither requester starves.
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous reset, active-high
//   bus  : mem_port_arbiter_if.slave (fetch, data, stall and memory command signals)
module mem_port_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);
    localparam int unsigned      CNT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

    typedef enum logic [1:0] {StIdle, StData, StFetch} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              last_fetch_q, last_fetch_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              if_valid_q, if_valid_d;
    logic              d_valid_q, d_valid_d;

    logic d_req, if_elig, d_elig, grant_data, grant_fetch;

    // A requester still holding its line during its completion cycle is not eligible.
    always_comb begin
        d_req       = bus.d_read | bus.d_write;
        if_elig     = bus.if_req & ~if_valid_q;
        d_elig      = d_req & ~d_valid_q;
        grant_data  = d_elig & (~if_elig | last_fetch_q);
        grant_fetch = if_elig & ~grant_data;
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_fetch_d = last_fetch_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        if_rdata_d   = if_rdata_q;
        d_rdata_d    = d_rdata_q;
        if_valid_d   = 1'b0;
        d_valid_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (grant_data) begin
                    state_d      = StData;
                    cnt_d        = '0;
                    last_fetch_d = 1'b0;
                    we_d         = bus.d_write;
                    addr_d       = bus.d_addr;
                    wdata_d      = bus.d_wdata;
                end else if (grant_fetch) begin
                    state_d      = StFetch;
                    cnt_d        = '0;
                    last_fetch_d = 1'b1;
                    we_d         = 1'b0;
                    addr_d       = bus.if_addr;
                end
            end
            StData, StFetch: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    if (state_q == StFetch) begin
                        if_rdata_d = bus.mem_rdata;
                        if_valid_d = 1'b1;
                    end else begin
                        d_valid_d = 1'b1;
                        // Writes (including read+write) leave load data untouched.
                        if (!we_q) begin
                            d_rdata_d = bus.mem_rdata;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            last_fetch_q <= 1'b1;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
            if_valid_q   <= 1'b0;
            d_valid_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_fetch_q <= last_fetch_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            if_rdata_q   <= if_rdata_d;
            d_rdata_q    <= d_rdata_d;
            if_valid_q   <= if_valid_d;
            d_valid_q    <= d_valid_d;
        end
    end

    always_comb begin
        bus.mem_en    = (state_q != StIdle);
        bus.mem_we    = we_q & (state_q == StData);
        bus.mem_addr  = addr_q;
        bus.mem_wdata = wdata_q;
        bus.if_rdata  = if_rdata_q;
        bus.if_valid  = if_valid_q;
        bus.d_rdata   = d_rdata_q;
        bus.d_valid   = d_valid_q;
        bus.stall     = (bus.if_req & ~if_valid_q) | (d_req & ~d_valid_q);
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
module tb_mem_port_arbiter;
    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;
    localparam int          LAT = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Bench memory: returns data only on the LAT-th consecutive command cycle.
    logic [31:0] mem [logic [31:0]];
    function automatic logic [31:0] rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'hBAD0_BAD0;
    endfunction

    int en_run = 0, en_total = 0, dv_total = 0, st_cnt = 0, we_total = 0;
    bit cmp_on = 0;

    // Transaction-level model
    bit          m_busy = 0, m_fetch = 0, m_wr = 0, m_last_fetch = 1;
    int          m_start = 0, m_ifv_at = -1, m_dv_at = -1;
    logic [31:0] m_addr = 0, m_wdata = 0, m_if_rdata = 0, m_d_rdata = 0;
    bit          glog[$];

    always @(negedge clk) begin
        bit exp_ifv, exp_dv, exp_en, exp_we, if_el, d_el;
        if (bus.mem_en === 1'b1) en_run++; else en_run = 0;
        bus.mem_rdata = (bus.mem_en === 1'b1 && en_run == LAT) ? rd(bus.mem_addr) : 32'hBAD0_BAD0;
        if (bus.mem_en === 1'b1) en_total++;
        if (bus.mem_we === 1'b1) we_total++;
        if (bus.d_valid === 1'b1) dv_total++;
        if (bus.mem_en === 1'b1 && bus.mem_we === 1'b1 && bus.mem_addr == 32'h104 &&
            bus.mem_wdata == 32'h1234_5678) st_cnt++;

        exp_ifv = (cyc == m_ifv_at);
        exp_dv  = (cyc == m_dv_at);
        exp_en  = m_busy && cyc >= m_start && cyc < m_start + LAT;
        exp_we  = exp_en && !m_fetch && m_wr;
        if (cmp_on) begin
            chk("if_valid", 32'(bus.if_valid), 32'(exp_ifv));
            chk("d_valid", 32'(bus.d_valid), 32'(exp_dv));
            chk("mem_en", 32'(bus.mem_en), 32'(exp_en));
            chk("mem_we", 32'(bus.mem_we), 32'(exp_we));
            chk("if_rdata", bus.if_rdata, m_if_rdata);
            chk("d_rdata", bus.d_rdata, m_d_rdata);
            chk("stall", 32'(bus.stall), 32'((bus.if_req && !exp_ifv) ||
                                               ((bus.d_read || bus.d_write) && !exp_dv)));
            if (exp_en) chk("mem_addr", bus.mem_addr, m_addr);
            if (exp_we) chk("mem_wdata", bus.mem_wdata, m_wdata);
        end

        if (rst) begin
            m_busy = 0; m_last_fetch = 1; m_if_rdata = 0; m_d_rdata = 0;
            m_ifv_at = -1; m_dv_at = -1;
        end else if (m_busy) begin
            if (cyc == m_start + LAT - 1) begin
                m_busy = 0;
                if (m_fetch) begin
                    m_if_rdata = rd(m_addr);
                    m_ifv_at   = cyc + 1;
                end else begin
                    m_dv_at = cyc + 1;
                    if (m_wr) mem[m_addr] = m_wdata;
                    else      m_d_rdata = rd(m_addr);
                end
            end
        end else begin
            if_el = bus.if_req && !exp_ifv;
            d_el  = (bus.d_read || bus.d_write) && !exp_dv;
            if (if_el || d_el) begin
                m_fetch      = d_el ? (if_el && !m_last_fetch) : 1'b1;
                m_busy       = 1;
                m_start      = cyc + 1;
                m_addr       = m_fetch ? bus.if_addr : bus.d_addr;
                m_wr         = !m_fetch && bus.d_write;
                m_wdata      = bus.d_wdata;
                m_last_fetch = m_fetch;
                glog.push_back(m_fetch);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input bit fetch, output int at);
        at = -1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if ((fetch ? bus.if_valid : bus.d_valid) === 1'b1) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL valid_timeout: no %s valid within 20 cycles", fetch ? "fetch" : "data");
        end
    endtask

    initial begin
        int t, at, at2, e0, w0, s0, d0, nd, nf;
        bus.if_req = 0; bus.if_addr = 0; bus.d_read = 0; bus.d_write = 0;
        bus.d_addr = 0; bus.d_wdata = 0; bus.mem_rdata = 0;
        mem[32'h40]  = 32'h0050_0093;
        mem[32'h100] = 32'hDEAD_BEEF;
        mem[32'h104] = 32'h0000_0000;
        mem[32'h108] = 32'h0000_0000;
        repeat (3) tick();
        rst = 0;
        cmp_on = 1;
        chk("reset_mem_en", 32'(bus.mem_en), 32'h0);
        chk("reset_if_rdata", bus.if_rdata, 32'h0);

        // Fetch only
        bus.if_req = 1; bus.if_addr = 32'h40; t = cyc; e0 = en_total;
        wait_valid(1, at);
        chk("fetch_latency", 32'(at - t), 32'd3);
        chk("fetch_rdata", bus.if_rdata, 32'h0050_0093);
        chk("fetch_stall_low", 32'(bus.stall), 32'h0);
        chk("fetch_en_cycles", 32'(en_total - e0), 32'd2);
        bus.if_req = 0;
        tick();

        // Load
        bus.d_read = 1; bus.d_addr = 32'h100; t = cyc; w0 = we_total;
        wait_valid(0, at);
        chk("load_latency", 32'(at - t), 32'd3);
        chk("load_rdata", bus.d_rdata, 32'hDEAD_BEEF);
        chk("load_if_rdata_kept", bus.if_rdata, 32'h0050_0093);
        chk("load_no_we", 32'(we_total - w0), 32'd0);
        bus.d_read = 0;
        tick();

        // Store
        bus.d_write = 1; bus.d_addr = 32'h104; bus.d_wdata = 32'h1234_5678;
        t = cyc; s0 = st_cnt;
        wait_valid(0, at);
        chk("store_latency", 32'(at - t), 32'd3);
        chk("store_stable_cycles", 32'(st_cnt - s0), 32'd2);
        chk("store_d_rdata_kept", bus.d_rdata, 32'hDEAD_BEEF);
        bus.d_write = 0;
        tick();

        // Read back the stored word
        bus.d_read = 1; bus.d_addr = 32'h104;
        wait_valid(0, at);
        chk("readback_rdata", bus.d_rdata, 32'h1234_5678);
        bus.d_read = 0;
        tick();

        // Read and write together behave as a write
        bus.d_read = 1; bus.d_write = 1; bus.d_addr = 32'h108; bus.d_wdata = 32'hCAFE_F00D;
        wait_valid(0, at);
        chk("rw_d_rdata_kept", bus.d_rdata, 32'h1234_5678);
        bus.d_write = 0; bus.d_addr = 32'h108;
        tick();
        wait_valid(0, at);
        chk("rw_readback", bus.d_rdata, 32'hCAFE_F00D);
        bus.d_read = 0;
        tick();

        // Reset in the middle of a load
        bus.d_read = 1; bus.d_addr = 32'h100;
        tick();
        chk("abort_mem_en_before", 32'(bus.mem_en), 32'h1);
        rst = 1; bus.d_read = 0; d0 = dv_total;
        tick();
        tick();
        rst = 0;
        chk("abort_mem_en", 32'(bus.mem_en), 32'h0);
        chk("abort_mem_we", 32'(bus.mem_we), 32'h0);
        chk("abort_mem_addr", bus.mem_addr, 32'h0);
        chk("abort_mem_wdata", bus.mem_wdata, 32'h0);
        chk("abort_d_rdata", bus.d_rdata, 32'h0);
        chk("abort_if_rdata", bus.if_rdata, 32'h0);
        chk("abort_stall", 32'(bus.stall), 32'h0);
        repeat (3) tick();
        chk("abort_no_d_valid", 32'(dv_total - d0), 32'd0);

        // Conflict right after reset: data first, then fetch
        glog.delete();
        bus.if_req = 1; bus.if_addr = 32'h40; bus.d_read = 1; bus.d_addr = 32'h100; t = cyc;
        wait_valid(0, at);
        chk("conflict_d_latency", 32'(at - t), 32'd3);
        bus.d_read = 0;
        wait_valid(1, at2);
        chk("conflict_if_latency", 32'(at2 - t), 32'd6);
        chk("conflict_stall_low", 32'(bus.stall), 32'h0);
        bus.if_req = 0;
        chk("conflict_grants", 32'(glog.size()), 32'd2);
        if (glog.size() == 2) begin
            chk("conflict_first_data", 32'(glog[0]), 32'h0);
            chk("conflict_then_fetch", 32'(glog[1]), 32'h1);
        end
        tick();

        // Back-to-back alternation with both lines held
        glog.delete();
        bus.if_req = 1; bus.if_addr = 32'h40; bus.d_read = 1; bus.d_addr = 32'h104;
        nd = 0; nf = 0;
        for (int i = 0; i < 40 && !(nd == 3 && nf == 3); i++) begin
            tick();
            if (bus.d_valid === 1'b1) nd++;
            if (bus.if_valid === 1'b1) nf++;
        end
        bus.if_req = 0; bus.d_read = 0;
        chk("alt_d_count", 32'(nd), 32'd3);
        chk("alt_f_count", 32'(nf), 32'd3);
        chk("alt_grant_count", 32'(glog.size()), 32'd6);
        for (int i = 0; i < glog.size(); i++) chk("alt_grant_order", 32'(glog[i]), 32'(i % 2));
        repeat (4) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
